// File: rtl/adc_scan_scheduler.sv
// rtl/adc_scan_scheduler.sv - 13-channel ADC scan sequencer over one internal and three external sources
// Optional abort of stalled conversions: define ADC_SCHED_TIMEOUT_EN.
module adc_scan_scheduler #(
    parameter int TIMEOUT_CYC = 65000,
    parameter int SCAN_GAP    = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  src_done,
    input  logic [47:0] src_data,
    output logic [3:0]  src_req,
    output logic [1:0]  src_ch,
    output logic [3:0]  res_ch,
    output logic [11:0] res_data,
    output logic        res_valid,
    output logic        res_timeout,
    output logic        scan_done,
    output logic [7:0]  timeout_cnt
);

    localparam int CNT_MAX = (TIMEOUT_CYC > SCAN_GAP) ? TIMEOUT_CYC : SCAN_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]       state;
    logic [3:0]       channel;
    logic [CNT_W-1:0] gap_cnt;
    logic [3:0]       ch_m1;
    logic [1:0]       cur_src;
    logic [1:0]       cur_sub;
    logic             done_hit;
    logic [11:0]      cur_data;

    // Channel 0 is the internal ADC; channels 1..12 fan out four per external ADC.
    always_comb begin
        ch_m1   = channel - 4'd1;
        cur_src = 2'd0;
        cur_sub = 2'd0;
        if (channel != 4'd0) begin
            cur_src = ch_m1[3:2] + 2'd1;
            cur_sub = ch_m1[1:0];
        end
        done_hit = src_done[cur_src];
        case (cur_src)
            2'd0:    cur_data = src_data[11:0];
            2'd1:    cur_data = src_data[23:12];
            2'd2:    cur_data = src_data[35:24];
            default: cur_data = src_data[47:36];
        endcase
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign res_timeout = 1'b0;
    assign timeout_cnt = 8'd0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            channel   <= 4'd0;
            gap_cnt   <= '0;
            src_req   <= 4'd0;
            src_ch    <= 2'd0;
            res_ch    <= 4'd0;
            res_data  <= 12'd0;
            res_valid <= 1'b0;
            scan_done <= 1'b0;
`ifdef ADC_SCHED_TIMEOUT_EN
            wait_cnt    <= '0;
            res_timeout <= 1'b0;
            timeout_cnt <= 8'd0;
`endif
        end else begin
            res_valid <= 1'b0;
            scan_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (scan_en) begin
                        channel <= 4'd0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    src_req <= 4'b0001 << cur_src;
                    src_ch  <= cur_sub;
`ifdef ADC_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A done landing on the expiry cycle wins over the abort.
                    if (done_hit) begin
                        src_req   <= 4'd0;
                        res_data  <= cur_data;
                        res_ch    <= channel;
                        res_valid <= 1'b1;
                        scan_done <= (channel == 4'd12);
`ifdef ADC_SCHED_TIMEOUT_EN
                        res_timeout <= 1'b0;
`endif
                        state     <= S_STORE;
                    end
`ifdef ADC_SCHED_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        src_req     <= 4'd0;
                        res_data    <= 12'h000;
                        res_ch      <= channel;
                        res_valid   <= 1'b1;
                        scan_done   <= (channel == 4'd12);
                        res_timeout <= 1'b1;
                        if (timeout_cnt != 8'hFF)
                            timeout_cnt <= timeout_cnt + 8'd1;
                        state       <= S_STORE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_STORE: begin
                    if (channel == 4'd12) begin
                        channel <= 4'd0;
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (scan_en) begin
                        channel <= channel + 4'd1;
                        state   <= S_ISSUE;
                    end else begin
                        channel <= 4'd0;
                        state   <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST)
                        state <= scan_en ? S_ISSUE : S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
